// File: rtl/matrix_vector_set_feeder.sv
// Stores NSETS A/B row pairs and streams them as vector sets, one per enabled cycle.
// Define MATRIX_FEED_DOUBLE_BUF_EN to add a second bank that can be refilled while the other streams.
module matrix_vector_set_feeder #(
  parameter int IN_WIDTH = 16,
  parameter int LANES    = 12,
  parameter int NSETS    = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      wr_en,
  input  logic                      wr_sel,
  input  logic [3:0]                wr_row,
  input  logic [LANES*IN_WIDTH-1:0] wr_vec,
  input  logic                      start,
  output logic                      inReady,
  output logic [3:0]                vectorSetInNo,
  output logic [LANES*IN_WIDTH-1:0] A_vec,
  output logic [LANES*IN_WIDTH-1:0] B_vec,
  output logic                      busy,
  output logic                      done,
  output logic                      wr_err,
  output logic                      start_err
);

  localparam int VW = LANES * IN_WIDTH;
  localparam int MW = 2 * NSETS;
`ifdef MATRIX_FEED_DOUBLE_BUF_EN
  localparam int NBANKS = 2;
`else
  localparam int NBANKS = 1;
`endif
  localparam int AW = $clog2(NBANKS * NSETS);
  localparam logic [3:0] LAST = 4'(NSETS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DONE} state_t;
  state_t state, state_next;

  logic [VW-1:0] a_mem [NBANKS*NSETS];
  logic [VW-1:0] b_mem [NBANKS*NSETS];
  logic [3:0]    idx;
  logic [MW-1:0] wr_mask, wr_bit;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          row_ok, wr_ok_state, set_full;
  logic          wr_acc, wr_rej, start_acc, start_rej;

`ifdef MATRIX_FEED_DOUBLE_BUF_EN
  logic [MW-1:0] mask [2];
  logic          wr_bank, rd_bank;
  assign wr_mask     = mask[wr_bank];
  assign wr_ok_state = 1'b1;
  assign wr_addr     = AW'(wr_row) + (wr_bank ? AW'(NSETS) : AW'(0));
  assign rd_addr     = AW'(idx) + (rd_bank ? AW'(NSETS) : AW'(0));
`else
  logic [MW-1:0] mask;
  assign wr_mask     = mask;
  // The single bank is being read while streaming, so it cannot be rewritten then.
  assign wr_ok_state = (state != ST_STREAM);
  assign wr_addr     = AW'(wr_row);
  assign rd_addr     = AW'(idx);
`endif

  // Mask layout: A rows in the low NSETS bits, B rows above them.
  assign row_ok   = int'(wr_row) < NSETS;
  assign wr_bit   = MW'(1) << (wr_sel ? (int'(wr_row) + NSETS) : int'(wr_row));
  assign set_full = &wr_mask;

  always_comb begin
    state_next = state;
    start_acc  = 1'b0;
    start_rej  = 1'b0;
    wr_acc     = wr_en && row_ok && wr_ok_state;
    wr_rej     = wr_en && !(row_ok && wr_ok_state);
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (set_full) begin
            start_acc  = 1'b1;
            state_next = ST_STREAM;
          end else begin
            start_rej = 1'b1;
          end
        end
      end
      ST_STREAM: if (idx == LAST) state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else if (enable) state <= state_next;
  end

  // Row storage survives reset.
  always_ff @(posedge clk) begin
    if (enable && wr_acc && !reset) begin
      if (wr_sel) b_mem[wr_addr] <= wr_vec;
      else        a_mem[wr_addr] <= wr_vec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx           <= '0;
      inReady       <= 1'b0;
      vectorSetInNo <= '0;
      A_vec         <= '0;
      B_vec         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      wr_err        <= 1'b0;
      start_err     <= 1'b0;
`ifdef MATRIX_FEED_DOUBLE_BUF_EN
      mask[0]       <= '0;
      mask[1]       <= '0;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
`else
      mask          <= '0;
`endif
    end else if (enable) begin
      inReady   <= (state == ST_STREAM);
      done      <= (state == ST_DONE);
      busy      <= (state_next == ST_STREAM);
      wr_err    <= wr_rej;
      start_err <= start_rej;
      if (state == ST_STREAM) begin
        vectorSetInNo <= idx;
        A_vec         <= a_mem[rd_addr];
        B_vec         <= b_mem[rd_addr];
        idx           <= (idx == LAST) ? '0 : idx + 4'd1;
      end
      if (start_acc) idx <= '0;
`ifdef MATRIX_FEED_DOUBLE_BUF_EN
      if (wr_acc) mask[wr_bank] <= mask[wr_bank] | wr_bit;
      // Stream the freshly filled bank; the other one becomes the new fill target.
      if (start_acc) begin
        rd_bank        <= wr_bank;
        wr_bank        <= ~wr_bank;
        mask[~wr_bank] <= '0;
      end
`else
      if (wr_acc) mask <= mask | wr_bit;
`endif
    end
  end

endmodule

// File: tb/tb_matrix_vector_set_feeder.sv
// Randomized bench for matrix_vector_set_feeder against a row-store / stream reference model.
module tb_matrix_vector_set_feeder;
  localparam int IN_WIDTH = 16;
  localparam int LANES    = 12;
  localparam int NSETS    = 10;
  localparam int VW       = IN_WIDTH * LANES;
`ifdef MATRIX_FEED_DOUBLE_BUF_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, enable, wr_en, wr_sel, start;
  logic [3:0]    wr_row;
  logic [VW-1:0] wr_vec;
  logic          inReady, busy, done, wr_err, start_err;
  logic [3:0]    vectorSetInNo;
  logic [VW-1:0] A_vec, B_vec;

  matrix_vector_set_feeder #(.IN_WIDTH(IN_WIDTH), .LANES(LANES), .NSETS(NSETS)) dut (
    .clk(clk), .reset(reset), .enable(enable), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_row(wr_row), .wr_vec(wr_vec), .start(start), .inReady(inReady),
    .vectorSetInNo(vectorSetInNo), .A_vec(A_vec), .B_vec(B_vec), .busy(busy),
    .done(done), .wr_err(wr_err), .start_err(start_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: rows and loaded flags per bank, fill/stream bank pointers.
  logic [VW-1:0] m_a [2][NSETS];
  logic [VW-1:0] m_b [2][NSETS];
  bit            m_ld_a [2][NSETS];
  bit            m_ld_b [2][NSETS];
  int            m_wb, m_rb;

  // Expected output values.
  logic          e_in, e_busy, e_done, e_werr, e_serr;
  logic [3:0]    e_no;
  logic [VW-1:0] e_a, e_b;

  task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".inReady"},   VW'(inReady),       VW'(e_in));
    chk({tag, ".setNo"},     VW'(vectorSetInNo), VW'(e_no));
    chk({tag, ".A_vec"},     A_vec,              e_a);
    chk({tag, ".B_vec"},     B_vec,              e_b);
    chk({tag, ".busy"},      VW'(busy),          VW'(e_busy));
    chk({tag, ".done"},      VW'(done),          VW'(e_done));
    chk({tag, ".wr_err"},    VW'(wr_err),        VW'(e_werr));
    chk({tag, ".start_err"}, VW'(start_err),     VW'(e_serr));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VW-1:0] splat(input int v);
    logic [VW-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*IN_WIDTH +: IN_WIDTH] = IN_WIDTH'(v);
    return r;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*IN_WIDTH +: IN_WIDTH] = IN_WIDTH'($urandom);
    return r;
  endfunction

  // Returns 1 when the write is rejected.
  function automatic bit model_write(input bit sel, input int row, input logic [VW-1:0] v,
                                     input bit streaming);
    if (row >= NSETS || (streaming && !DB)) return 1'b1;
    if (sel) begin m_b[m_wb][row] = v; m_ld_b[m_wb][row] = 1'b1; end
    else     begin m_a[m_wb][row] = v; m_ld_a[m_wb][row] = 1'b1; end
    return 1'b0;
  endfunction

  function automatic bit model_full();
    for (int r = 0; r < NSETS; r++)
      if (!m_ld_a[m_wb][r] || !m_ld_b[m_wb][r]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_clear(input int bank);
    for (int r = 0; r < NSETS; r++) begin m_ld_a[bank][r] = 1'b0; m_ld_b[bank][r] = 1'b0; end
  endfunction

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'($urandom_range(0, 1));
    tick();
    reset = 1'b0;
    model_clear(0);
    model_clear(1);
    m_wb = 0; m_rb = 0;
    e_in = 0; e_no = '0; e_a = '0; e_b = '0; e_busy = 0; e_done = 0; e_werr = 0; e_serr = 0;
    check_all("reset");
  endtask

  task automatic write_row(input bit sel, input int row, input logic [VW-1:0] v);
    enable = 1'b1; wr_en = 1'b1; wr_sel = sel; wr_row = 4'(row); wr_vec = v;
    e_werr = model_write(sel, row, v, 1'b0);
    tick();
    wr_en = 1'b0;
    e_serr = 0; e_in = 0; e_done = 0; e_busy = 0;
    check_all("write");
  endtask

  task automatic do_start(output bit ok);
    ok = model_full();
    enable = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    e_in = 0; e_done = 0; e_werr = 0; e_serr = !ok; e_busy = ok;
    check_all("start");
    if (ok) begin
      m_rb = m_wb;
      if (DB) begin
        m_wb = 1 - m_wb;
        model_clear(m_wb);
      end
    end
  endtask

  // en_mode: 0 always enabled, 1 alternating 1,0,1,0..., 2 random.
  task automatic stream(input int en_mode, input int n_wr, input int abort_at);
    int n = 0;
    int wi = 0;
    int cyc = 0;
    bit done_seen = 0;
    bit idle_seen = 0;
    bit en, wrote, rej;
    while (!(idle_seen && wi >= n_wr) && cyc < 200) begin
      cyc++;
      case (en_mode)
        0:       en = 1'b1;
        1:       en = (cyc % 2) == 1;
        default: en = 1'($urandom_range(0, 1));
      endcase
      enable = en;
      start  = done_seen ? 1'b0 : 1'($urandom_range(0, 1));
      wrote  = en && (wi < n_wr);
      rej    = 1'b0;
      wr_en  = wrote;
      if (wrote) begin
        wr_sel = (wi >= NSETS);
        wr_row = 4'(wi % NSETS);
        wr_vec = rand_vec();
        rej    = model_write(wi >= NSETS, wi % NSETS, wr_vec, n < NSETS);
        wi++;
      end
      tick();
      wr_en = 1'b0;
      start = 1'b0;
      if (en) begin
        e_werr = wrote && rej;
        e_serr = 0;
        if (n < NSETS) begin
          e_in = 1; e_no = 4'(n); e_a = m_a[m_rb][n]; e_b = m_b[m_rb][n]; e_done = 0;
          n++;
          e_busy = (n < NSETS);
        end else if (!done_seen) begin
          e_in = 0; e_done = 1; e_busy = 0; done_seen = 1;
        end else begin
          e_in = 0; e_done = 0; e_busy = 0; idle_seen = 1;
        end
      end
      check_all("stream");
      if (en && abort_at >= 0 && n - 1 == abort_at && !done_seen) return;
    end
    chk("stream_completed", VW'(idle_seen), VW'(1));
    chk("strobe_count", VW'(n), VW'(NSETS));
  endtask

  bit ok;

  initial begin
    reset = 1'b1; enable = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_row = '0; wr_vec = '0; start = 1'b0;
    m_wb = 0; m_rb = 0;
    do_reset();

    for (int r = 0; r < NSETS; r++) begin
      write_row(1'b0, r, splat(r));
      write_row(1'b1, r, splat(100 + r));
    end
    do_start(ok);
`ifdef MATRIX_FEED_DOUBLE_BUF_EN
    if (ok) stream(0, 2 * NSETS, -1);
    do_start(ok);
    if (ok) stream(2, 0, -1);
`else
    if (ok) stream(0, 0, -1);
    do_start(ok);
    if (ok) stream(1, 2, -1);
    for (int it = 0; it < 3; it++) begin
      for (int r = 0; r < NSETS; r++) begin
        write_row(1'b0, r, rand_vec());
        write_row(1'b1, r, rand_vec());
      end
      write_row(1'($urandom_range(0, 1)), $urandom_range(NSETS, 15), rand_vec());
      do_start(ok);
      if (ok) stream(2, 3, -1);
    end
`endif

    // Reset in the middle of a stream, then a start must be refused.
    do_reset();
    for (int r = 0; r < NSETS; r++) begin
      write_row(1'b0, r, rand_vec());
      write_row(1'b1, r, rand_vec());
    end
    do_start(ok);
    if (ok) stream(0, 0, 4);
    do_reset();
    do_start(ok);

    // Incomplete A matrix plus an out-of-range row.
    for (int r = 0; r < NSETS; r++) write_row(1'b1, r, rand_vec());
    for (int r = 0; r < NSETS - 1; r++) write_row(1'b0, r, rand_vec());
    write_row(1'b0, 12, rand_vec());
    do_start(ok);
    repeat (3) begin
      enable = 1'b1;
      tick();
      e_serr = 0;
      check_all("idle");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/matrix_vector_set_feeder.md
MATRIX_VECTOR_SET_FEEDER -- requirements
Module: matrix_vector_set_feeder

Interface
REQ-001 Parameter: IN_WIDTH, default 16, element width in bits (signed).
REQ-002 Parameter: LANES, default 12, elements per vector.
REQ-003 Parameter: NSETS, default 10, vector sets per matrix.
REQ-004 Reset is reset: synchronous, active-high; clock is clk. All logic samples on posedge clk.
REQ-005 Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- enable  in  1  global clock-enable; all state holds while low
- wr_en  in  1  row write strobe
- wr_sel  in  1  0 = matrix A, 1 = matrix B
- wr_row  in  4  row index, 0..NSETS-1
- wr_vec  in  LANES*IN_WIDTH  row data; lane k at bits [k*IN_WIDTH +: IN_WIDTH]
- start  in  1  request to stream one matrix pair
- inReady  out  1  vector-set-valid strobe to the adder
- vectorSetInNo  out  4  index of the set currently presented
- A_vec  out  LANES*IN_WIDTH  A row presented
- B_vec  out  LANES*IN_WIDTH  B row presented
- busy  out  1  high in STREAM
- done  out  1  one-cycle pulse after the last set
- wr_err  out  1  one-cycle pulse on a rejected write
- start_err  out  1  one-cycle pulse on a rejected start

Function
REQ-006 Storage: one bank holds NSETS A rows and NSETS B rows, plus a 2*NSETS-bit loaded mask.
REQ-007 An accepted write (enable=1, wr_en=1, wr_row<NSETS, target bank writable) stores wr_vec and sets the matching mask bit on the next edge.
REQ-008 A write with wr_row>=NSETS is dropped; wr_err pulses for 1 cycle.
REQ-009 States: IDLE, STREAM, DONE. Reset state is IDLE.
REQ-010 IDLE->STREAM on start=1 with the selected bank mask all-ones; idx clears to 0.
REQ-011 start in IDLE with an incomplete mask is ignored; start_err pulses for 1 cycle; state stays IDLE.
REQ-012 start in STREAM or DONE is ignored silently.
REQ-013 STREAM: each enabled cycle registers inReady=1, vectorSetInNo=idx, A_vec=A[idx], B_vec=B[idx]; idx increments.
REQ-014 Latency: start accepted at edge t gives the first inReady at t+1 with vectorSetInNo=0, and the last at t+NSETS with vectorSetInNo=NSETS-1.
REQ-015 After idx=NSETS-1 is issued, the FSM moves to DONE. done=1 for exactly one cycle, with inReady=0, then the FSM returns to IDLE.
REQ-016 vectorSetInNo wraps NSETS-1->0 and never exceeds NSETS-1; inReady is 0 outside STREAM.
REQ-017 enable=0 freezes state, idx, mask and all outputs. Pulses (done, wr_err, start_err) stretch until the next enabled cycle.
REQ-018 Mask persists after a stream, so the same pair can be restreamed by start alone.
REQ-019 Outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-020 Reset at any cycle, including mid-STREAM, aborts to IDLE within one edge and clears the mask(s) and idx.
REQ-021 Reset forces inReady=0, vectorSetInNo=0, A_vec=0, B_vec=0, busy=0, done=0, wr_err=0, start_err=0.
REQ-022 Stored row data is not cleared by reset.

Configuration
REQ-023 Macro MATRIX_FEED_DOUBLE_BUF_EN.
REQ-024 Without the macro:
- one bank only
- writes in STREAM are dropped with a wr_err pulse
REQ-025 With the macro:
- two banks plus a wr_bank pointer (reset 0)
- writes always target wr_bank, in any state
- an accepted start streams wr_bank, toggles wr_bank and clears the new wr_bank's mask

Verification
REQ-026 Load A[r]=r and B[r]=100+r (all lanes), rows 0..9, then start -> inReady high for 10 consecutive cycles; vectorSetInNo 0..9; A lane0=r, B lane0=100+r; then done pulses once.
REQ-027 Load only 9 A rows, then start -> start_err pulses once; inReady stays 0.
REQ-028 Toggle enable 1,0,1,0 during STREAM -> the sequence 0..9 is unbroken, with values held on disabled cycles; 10 strobes total.
REQ-029 Assert reset at vectorSetInNo=4 -> the next cycle shows IDLE and all outputs 0; a following start gives start_err.
REQ-030 wr_row=12 -> wr_err pulses; mask unchanged.
REQ-031 With MATRIX_FEED_DOUBLE_BUF_EN: load bank0, start, and during STREAM load bank1 with distinct data; start again after done -> bank1 data streams, with no wr_err.
